bayer_quad_binner: RTL and testbench

// - Downstream of the per-pixel Bayer channel splitter. Consumes its masked R/G/B streams plus raw X/Y counts.
// - Bins each 2x2 Bayer quad (G1 R / B G2) into one full-colour RGB pixel.
// - Output is a half-resolution RGB stream, 320x240 for a 640x480 input, for the object-tracking colour stages.
// - Uses a one-row pair buffer so the even row can be merged with the following odd row.

---
 rtl/bayer_quad_binner.sv | 140 ++++++++++++++
 tb/tb_bayer_quad_binner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_quad_binner.sv
// Bins each 2x2 Bayer quad (G1 R / B G2) into one RGB pixel at half resolution.
// The even row of a quad is parked in a one-row pair buffer until its odd row arrives.
module bayer_quad_binner #(
  parameter int IMG_WIDTH = 640,
  parameter int DW        = 12,
  parameter int CW        = 11
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  input  logic          iDVAL,
  input  logic [CW-1:0] iX_Cont,
  input  logic [CW-1:0] iY_Cont,
  output logic [DW-1:0] oRed,
  output logic [DW-1:0] oGreen,
  output logic [DW-1:0] oBlue,
  output logic          oDVAL,
  output logic [CW-2:0] oX_Cont,
  output logic [CW-2:0] oY_Cont
);

  localparam int DEPTH = IMG_WIDTH / 2;
  localparam int AW    = $clog2(DEPTH);

  logic            acc_w;
  logic            odd_col_w;
  logic            odd_row_w;
  logic [CW-2:0]   pidx_w;
  logic [CW-2:0]   ytag_w;
  logic [AW-1:0]   addr_w;
  logic            same_y_w;
  logic            pair_w;
  logic            wr_w;
  logic            rd_w;
  logic            emit_w;
  logic [DW-1:0]   green_w;

  logic            half_v_q, half_v_d;
  logic [CW-2:0]   idx_q, idx_d;
  logic [DW-1:0]   lat_q, lat_d;
  logic [CW-1:0]   y_q, y_d;
  logic            tag_v_q, tag_v_d;
  logic [CW-2:0]   tag_q, tag_d;

  logic [DW-1:0]   red_q, grn_q, blu_q;
  logic            dval_q;
  logic [CW-2:0]   ox_q, oy_q;

  logic [2*DW-1:0] mem [DEPTH];
  logic [2*DW-1:0] rd_q;

  assign acc_w     = iDVAL && (iX_Cont < CW'(IMG_WIDTH));
  assign odd_col_w = iX_Cont[0];
  assign odd_row_w = iY_Cont[0];
  assign pidx_w    = iX_Cont[CW-1:1];
  assign ytag_w    = iY_Cont[CW-1:1];
  assign addr_w    = AW'(pidx_w);
  assign same_y_w  = (iY_Cont == y_q);

  assign pair_w = acc_w && odd_col_w && half_v_q
               && same_y_w && (idx_q == pidx_w);
  assign wr_w   = pair_w && !odd_row_w;
  assign rd_w   = acc_w && !odd_col_w && odd_row_w;
  assign emit_w = pair_w && odd_row_w
               && tag_v_q && (tag_q == ytag_w);

  // 13-bit sum keeps the carry before halving
  assign green_w = DW'(({1'b0, rd_q[DW-1:0]}
                      + {1'b0, iGreen}) >> 1);

  always_comb begin
    half_v_d = half_v_q;
    idx_d    = idx_q;
    lat_d    = lat_q;
    y_d      = y_q;
    tag_v_d  = tag_v_q;
    tag_d    = tag_q;
    if (acc_w) begin
      y_d = iY_Cont;
      if (!odd_col_w) begin
        half_v_d = 1'b1;
        idx_d    = pidx_w;
        lat_d    = odd_row_w ? iBlue : iGreen;
      end else if (pair_w || !same_y_w) begin
        half_v_d = 1'b0;
      end
      if (wr_w) begin
        tag_v_d = 1'b1;
        tag_d   = ytag_w;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (wr_w) mem[addr_w] <= {iRed, lat_q};
    if (rd_w) rd_q <= mem[addr_w];
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      half_v_q <= 1'b0;
      idx_q    <= '0;
      lat_q    <= '0;
      y_q      <= '0;
      tag_v_q  <= 1'b0;
      tag_q    <= '0;
      red_q    <= '0;
      grn_q    <= '0;
      blu_q    <= '0;
      dval_q   <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
    end else begin
      half_v_q <= half_v_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      y_q      <= y_d;
      tag_v_q  <= tag_v_d;
      tag_q    <= tag_d;
      dval_q   <= emit_w;
      if (emit_w) begin
        red_q <= rd_q[2*DW-1:DW];
        grn_q <= green_w;
        blu_q <= lat_q;
        ox_q  <= pidx_w;
        oy_q  <= ytag_w;
      end
    end
  end

  assign oRed    = red_q;
  assign oGreen  = grn_q;
  assign oBlue   = blu_q;
  assign oDVAL   = dval_q;
  assign oX_Cont = ox_q;
  assign oY_Cont = oy_q;

endmodule

// File: tb/tb_bayer_quad_binner.sv
// Bench for bayer_quad_binner: directed scenarios plus random rows,
// scored against an image-level quad model.
module tb_bayer_quad_binner;

  localparam int W  = 640;
  localparam int DW = 12;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] r_i, g_i, b_i;
  logic          dv_i;
  logic [CW-1:0] x_i, y_i;
  logic [DW-1:0] r_o, g_o, b_o;
  logic          dv_o;
  logic [CW-2:0] x_o, y_o;

  int vectors = 0;
  int miscompares = 0;

  logic [55:0] obs_q[$];
  logic [55:0] exp_q[$];

  int ev_y, cur_y, last_even_x, last_even_val;
  bit ev_ok[W/2];
  int ev_r[W/2];
  int ev_g[W/2];

  bayer_quad_binner #(.IMG_WIDTH(W), .DW(DW), .CW(CW)) dut (
    .iCLK(clk), .iRST(rst_n),
    .iRed(r_i), .iGreen(g_i), .iBlue(b_i),
    .iDVAL(dv_i), .iX_Cont(x_i), .iY_Cont(y_i),
    .oRed(r_o), .oGreen(g_o), .oBlue(b_o),
    .oDVAL(dv_o), .oX_Cont(x_o), .oY_Cont(y_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (dv_o === 1'b1)
      obs_q.push_back({r_o, g_o, b_o, x_o, y_o});
  end

  function automatic logic [55:0] pk(int r, int g, int b, int x, int y);
    return {12'(r), 12'(g), 12'(b), 10'(x), 10'(y)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ev_y = -1;
    cur_y = -1;
    last_even_x = -1;
    last_even_val = 0;
    for (int i = 0; i < W/2; i++) ev_ok[i] = 1'b0;
  endtask

  // Quad-level view: a quad emits once its odd-row pair completes and
  // the directly preceding even row supplied the same column pair.
  task automatic model_step(int x, int y, int r, int g, int b);
    int p;
    if (x >= W) return;
    if (y != cur_y) begin
      cur_y = y;
      last_even_x = -1;
      if (y % 2 == 0) begin
        ev_y = y;
        for (int i = 0; i < W/2; i++) ev_ok[i] = 1'b0;
      end
    end
    if (x % 2 == 0) begin
      last_even_x = x;
      last_even_val = (y % 2 == 1) ? b : g;
    end else if (last_even_x == x - 1) begin
      p = x / 2;
      last_even_x = -1;
      if (y % 2 == 0) begin
        ev_ok[p] = 1'b1;
        ev_r[p] = r;
        ev_g[p] = last_even_val;
      end else if (ev_y == y - 1 && ev_ok[p]) begin
        exp_q.push_back(pk(ev_r[p], (ev_g[p] + g) >> 1,
                           last_even_val, p, y / 2));
      end
    end
  endtask

  task automatic drive(bit dv, int x, int y, int r, int g, int b);
    @(negedge clk);
    dv_i = dv;
    x_i  = CW'(x);
    y_i  = CW'(y);
    r_i  = DW'(r);
    g_i  = DW'(g);
    b_i  = DW'(b);
    if (rst_n && dv) model_step(x, y, r, g, b);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      drive(0, $urandom_range(0, W - 1), 0,
            $urandom_range(0, 4095), $urandom_range(0, 4095),
            $urandom_range(0, 4095));
  endtask

  // Masks the three channel values down to the one present at (x,y)
  task automatic send_px(int x, int y, int rv, int gv, int bv);
    int r, g, b;
    r = 0; g = 0; b = 0;
    if (y % 2 == 0) begin
      if (x % 2 == 0) g = gv; else r = rv;
    end else begin
      if (x % 2 == 0) b = bv; else g = gv;
    end
    drive(1, x, y, r, g, b);
  endtask

  task automatic send_row(int y, bit flat, bit gaps);
    for (int x = 0; x < W; x++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      if (flat) send_px(x, y, 12'h200, 12'h100, 12'h300);
      else send_px(x, y, $urandom_range(0, 4095),
                   $urandom_range(0, 4095), $urandom_range(0, 4095));
    end
  endtask

  task automatic check_phase(string name, int n);
    idle(3);
    chk({name, "_count"}, obs_q.size(), n);
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk(name, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b1;
    dv_i = 0; x_i = '0; y_i = '0;
    r_i = '0; g_i = '0; b_i = '0;
    model_reset();
    #1 rst_n = 1'b0;

    // reset held while stimulus is active
    for (int i = 0; i < 6; i++)
      send_px(i, i / 2, 12'hABC, 12'h123, 12'h456);
    @(posedge clk); #1;
    chk("rst_dval", dv_o, 0);
    chk("rst_red", r_o, 0);
    chk("rst_green", g_o, 0);
    chk("rst_blue", b_o, 0);
    chk("rst_x", x_o, 0);
    chk("rst_y", y_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    obs_q.delete();

    // flat 640x2 frame
    send_row(0, 1, 0);
    idle(2);
    chk("flat_even_quiet", obs_q.size(), 0);
    send_row(1, 1, 0);
    idle(3);
    if (obs_q.size() == 320) begin
      chk("flat_first", obs_q[0], pk(12'h200, 12'h100, 12'h300, 0, 0));
      chk("flat_last", obs_q[319], pk(12'h200, 12'h100, 12'h300, 319, 0));
    end
    check_phase("flat", 320);

    // one-cycle latency on odd row
    send_row(2, 0, 0);
    for (int x = 0; x < 7; x++)
      send_px(x, 3, $urandom_range(0, 4095),
              $urandom_range(0, 4095), $urandom_range(0, 4095));
    send_px(7, 3, 0, $urandom_range(0, 4095), 0);
    chk("lat_pre", dv_o, 0);
    @(posedge clk); #1;
    chk("lat_dval", dv_o, 1);
    chk("lat_x", x_o, 3);
    chk("lat_y", y_o, 1);
    for (int x = 8; x < W; x++)
      send_px(x, 3, $urandom_range(0, 4095),
              $urandom_range(0, 4095), $urandom_range(0, 4095));
    check_phase("latency", 320);

    // green averaging extremes
    send_px(0, 4, 0, 12'hFFF, 0);
    send_px(1, 4, 12'h0A5, 0, 0);
    send_px(2, 4, 0, 12'hFFF, 0);
    send_px(3, 4, 12'h05A, 0, 0);
    send_px(4, 4, 0, 12'hFFF, 0);
    send_px(5, 4, 12'hFFF, 0, 0);
    send_px(0, 5, 0, 0, 12'h111);
    send_px(1, 5, 0, 12'h001, 0);
    send_px(2, 5, 0, 0, 12'h222);
    send_px(3, 5, 0, 12'h000, 0);
    send_px(4, 5, 0, 0, 12'hFFF);
    send_px(5, 5, 0, 12'hFFF, 0);
    idle(3);
    if (obs_q.size() == 3) begin
      chk("green_fff_001", obs_q[0][43:32], 12'h800);
      chk("green_fff_000", obs_q[1][43:32], 12'h7FF);
      chk("all_fff", obs_q[2], pk(12'hFFF, 12'hFFF, 12'hFFF, 2, 2));
    end
    check_phase("green", 3);

    // reset mid-row, then an odd row with no even row
    for (int x = 0; x < 100; x++)
      send_px(x, 6, $urandom_range(0, 4095),
              $urandom_range(0, 4095), $urandom_range(0, 4095));
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    obs_q.delete();
    exp_q.delete();
    send_row(1, 0, 0);
    check_phase("odd_first", 0);
    send_row(0, 0, 0);
    send_row(1, 0, 0);
    check_phase("frame2", 320);

    // gaps, lone odd pixel X=5, out-of-range X=700/701
    send_row(2, 0, 1);
    for (int x = 0; x < W; x++) begin
      if (x == 4) continue;
      if ($urandom_range(0, 3) == 0) idle(1);
      send_px(x, 3, $urandom_range(0, 4095),
              $urandom_range(0, 4095), $urandom_range(0, 4095));
      if (x == 6) begin
        drive(1, 700, 3, 0, 0, 12'h777);
        drive(1, 701, 3, 0, 12'h555, 0);
        drive(0, 9, 3, 0, 12'h999, 0);
      end
    end
    check_phase("gaps", 319);

    // random frames across Y wrap
    for (int f = 0; f < 2; f++) begin
      for (int y = 0; y < 4; y++) send_row(y, 0, 1);
      check_phase("rand", 640);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
